// File: rtl/tcam_pkg.sv
// Shared types and constants for the ternary CAM: FSM state encoding and
// 7-segment digit patterns (abcdefg, active high) used when TCAM_SEG7_EN is defined.
package tcam_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } tcam_state_t;

    localparam logic [6:0] SEG7_0 = 7'b1111110;
    localparam logic [6:0] SEG7_1 = 7'b0110000;
    localparam logic [6:0] SEG7_2 = 7'b1101101;
    localparam logic [6:0] SEG7_3 = 7'b1111001;
    localparam logic [6:0] SEG7_4 = 7'b0110011;
    localparam logic [6:0] SEG7_5 = 7'b1011011;
    localparam logic [6:0] SEG7_6 = 7'b1011111;
    localparam logic [6:0] SEG7_7 = 7'b1110000;
    localparam logic [6:0] SEG7_8 = 7'b1111111;
    localparam logic [6:0] SEG7_9 = 7'b1111011;

    function automatic logic [6:0] seg7_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg7_digit = SEG7_0;
            4'd1:    seg7_digit = SEG7_1;
            4'd2:    seg7_digit = SEG7_2;
            4'd3:    seg7_digit = SEG7_3;
            4'd4:    seg7_digit = SEG7_4;
            4'd5:    seg7_digit = SEG7_5;
            4'd6:    seg7_digit = SEG7_6;
            4'd7:    seg7_digit = SEG7_7;
            4'd8:    seg7_digit = SEG7_8;
            4'd9:    seg7_digit = SEG7_9;
            default: seg7_digit = SEG7_0;
        endcase
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder over the match vector: lowest set index wins,
// multi flags two or more set bits. idx is 0 when nothing is set.
module tcam_prio_enc #(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  vec,
    output logic              hit,
    output logic [ADDR_W-1:0] idx,
    output logic              multi
);

    always_comb begin
        hit   = |vec;
        // Clearing the lowest set bit leaves something only if a second bit was set.
        multi = |(vec & (vec - DEPTH'(1)));
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = ADDR_W'(i);
        end
    end

endmodule

// File: rtl/tcam_ternary.sv
// Ternary CAM with a 2-stage search pipeline (match vector, then priority result)
// and a sequential clear sweep. Define TCAM_SEG7_EN to add 7-segment outputs of rslt_addr.
module tcam_ternary
    import tcam_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              wr_valid,
    input  logic              clr,
    input  logic              srch_valid,
    input  logic [DATA_W-1:0] srch_key,
    output logic              srch_ready,
    output logic              busy,
    output logic              rslt_valid,
    output logic              rslt_hit,
    output logic [ADDR_W-1:0] rslt_addr,
    output logic              rslt_multi,
`ifdef TCAM_SEG7_EN
    output logic [6:0]        seg_lo,
    output logic [6:0]        seg_hi,
`endif
    output tcam_state_t       state
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] cnt;
    logic [DEPTH-1:0]  match_c;
    logic [DEPTH-1:0]  match_q;
    logic              s1_valid;
    logic              srch_acc;
    logic              wr_ok;
    logic              enc_hit;
    logic              enc_multi;
    logic [ADDR_W-1:0] enc_idx;

    assign busy       = (state == CLEAR);
    assign srch_ready = ~busy;
    assign srch_acc   = srch_valid & srch_ready;
    assign wr_ok      = wr_en & (state == IDLE) & ({1'b0, wr_addr} < DEPTH_L);

    // Compare against the registered contents, so a same-cycle write is not yet visible.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_c[i] = valid_q[i] && (((srch_key ^ data_q[i]) & ~mask_q[i]) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_q[wr_addr] <= wr_data;
            mask_q[wr_addr] <= wr_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= '0;
        end else if (state == IDLE) begin
            if (wr_ok) valid_q[wr_addr] <= wr_valid;
            if (clr) begin
                state <= CLEAR;
                cnt   <= '0;
            end
        end else begin
            valid_q[cnt] <= 1'b0;
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    tcam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
        .vec   (match_q),
        .hit   (enc_hit),
        .idx   (enc_idx),
        .multi (enc_multi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q    <= '0;
            s1_valid   <= 1'b0;
            rslt_valid <= 1'b0;
            rslt_hit   <= 1'b0;
            rslt_addr  <= '0;
            rslt_multi <= 1'b0;
        end else begin
            match_q    <= match_c;
            s1_valid   <= srch_acc;
            rslt_valid <= s1_valid;
            rslt_hit   <= s1_valid & enc_hit;
            rslt_multi <= s1_valid & enc_multi;
            rslt_addr  <= (s1_valid && enc_hit) ? enc_idx : '0;
        end
    end

`ifdef TCAM_SEG7_EN
    int idx_i;
    assign idx_i = int'(enc_idx);

    // Display holds the last hit address; misses leave it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_lo <= SEG7_0;
            seg_hi <= SEG7_0;
        end else if (s1_valid && enc_hit) begin
            seg_lo <= seg7_digit(4'(idx_i % 10));
            seg_hi <= seg7_digit(4'(idx_i / 10));
        end
    end
`endif

endmodule

// File: tb/tb_tcam_ternary.sv
// Scoreboard bench for tcam_ternary: stimulus pushes model predictions into a
// queue, a negedge monitor pops and compares every result strobe.
module tb_tcam_ternary;
    import tcam_pkg::*;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int RW     = ADDR_W + 2;

    logic              clk;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_mask;
    logic              wr_valid;
    logic              clr;
    logic              srch_valid;
    logic [DATA_W-1:0] srch_key;
    logic              srch_ready;
    logic              busy;
    logic              rslt_valid;
    logic              rslt_hit;
    logic [ADDR_W-1:0] rslt_addr;
    logic              rslt_multi;
    tcam_state_t       state;
`ifdef TCAM_SEG7_EN
    logic [6:0]        seg_lo;
    logic [6:0]        seg_hi;
`endif

    tcam_ternary #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wr_valid   (wr_valid),
        .clr        (clr),
        .srch_valid (srch_valid),
        .srch_key   (srch_key),
        .srch_ready (srch_ready),
        .busy       (busy),
        .rslt_valid (rslt_valid),
        .rslt_hit   (rslt_hit),
        .rslt_addr  (rslt_addr),
        .rslt_multi (rslt_multi),
`ifdef TCAM_SEG7_EN
        .seg_lo     (seg_lo),
        .seg_hi     (seg_hi),
`endif
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic [DATA_W-1:0] m_mask  [DEPTH];
    bit                m_valid [DEPTH];
    int                clear_left = 0;

    // Result packed as {hit, multi, addr}.
    function automatic logic [RW-1:0] model_search(input logic [DATA_W-1:0] key);
        int n;
        int first;
        n = 0;
        first = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((key ^ m_data[i]) & ~m_mask[i]) == '0)) begin
                if (n == 0) first = i;
                n++;
            end
        end
        return {n > 0, n > 1, ADDR_W'(first)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q [$];
    int            exp_cyc [$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rslt_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got strobe with hit=%0b addr=%0d, expected none (t=%0t)",
                         rslt_hit, rslt_addr, $time);
            end else begin
                logic [RW-1:0] e;
                int            ec;
                e  = exp_q.pop_front();
                ec = exp_cyc.pop_front();
                check("result", 32'({rslt_hit, rslt_multi, rslt_addr}), 32'(e));
                check("latency", 32'(cyc), 32'(ec));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_mask    = '0;
        wr_valid   = 1'b0;
        clr        = 1'b0;
        srch_valid = 1'b0;
        srch_key   = '0;
    endtask

    // Apply currently driven inputs for one clock and advance the model.
    task automatic tick();
        if (srch_valid && clear_left == 0) begin
            exp_q.push_back(model_search(srch_key));
            exp_cyc.push_back(cyc + 2);
        end
        @(posedge clk);
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (wr_en && int'(wr_addr) < DEPTH) begin
                m_data[wr_addr]  = wr_data;
                m_mask[wr_addr]  = wr_mask;
                m_valid[wr_addr] = wr_valid;
            end
            if (clr) begin
                clear_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end
        end
        #1;
        idle_inputs();
        check("busy", 32'(busy), 32'(clear_left != 0));
        check("srch_ready", 32'(srch_ready), 32'(clear_left == 0));
    endtask

    task automatic set_write(input int a, input logic [DATA_W-1:0] d,
                             input logic [DATA_W-1:0] m, input logic v);
        wr_en    = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_data  = d;
        wr_mask  = m;
        wr_valid = v;
    endtask

    task automatic set_search(input logic [DATA_W-1:0] k);
        srch_valid = 1'b1;
        srch_key   = k;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_rslt_valid"}, 32'(rslt_valid), 32'd0);
        check({tag, "_rslt_hit"},   32'(rslt_hit),   32'd0);
        check({tag, "_rslt_addr"},  32'(rslt_addr),  32'd0);
        check({tag, "_rslt_multi"}, 32'(rslt_multi), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Assert reset between edges, flush everything in flight, release on a negedge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_reset(tag);
        exp_q.delete();
        exp_cyc.delete();
        clear_left = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_state_idle"}, 32'(state), 32'(IDLE));
        check({tag, "_srch_ready"}, 32'(srch_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int busy_cnt;
        int e;

        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = '0;
            m_mask[i]  = '0;
            m_valid[i] = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_outputs_reset("reset");
        check("reset_state", 32'(state), 32'(IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_srch_ready", 32'(srch_ready), 32'd1);

        // single exact-match entry
        set_write(3, 10'h2A5, 10'h000, 1'b1); tick();
        set_search(10'h2A5); tick();
        repeat (3) tick();

        // masked entry 5 outranks exact entry 9, both match
        set_write(3, 10'h2A5, 10'h000, 1'b0); tick();
        set_write(5, 10'h200, 10'h0FF, 1'b1); tick();
        set_write(9, 10'h2A5, 10'h000, 1'b1); tick();
        set_search(10'h2A5); tick();
        repeat (3) tick();

        // back-to-back hit, miss, hit
        set_search(10'h2A5); tick();
        set_search(10'h111); tick();
        set_search(10'h2A5); tick();
        repeat (3) tick();

        // write and search same entry in the same cycle, then repeat the search
        set_write(7, 10'h0F0, 10'h000, 1'b1); set_search(10'h0F0); tick();
        set_search(10'h0F0); tick();
        repeat (3) tick();

        // clear sweep: writes, clr and searches inside the window are ignored
        clr = 1'b1; tick();
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (busy) busy_cnt++;
            if (i == 2) set_write(2, 10'h2A5, 10'h000, 1'b1);
            if (i == 5) clr = 1'b1;
            if (i == 7) set_search(10'h2A5);
            tick();
        end
        check("clear_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        set_search(10'h2A5); tick();
        set_search(10'h200); tick();
        repeat (3) tick();

        // reset during cycle 4 of CLEAR
        set_write(4, 10'h155, 10'h000, 1'b1); tick();
        clr = 1'b1; tick();
        repeat (3) tick();
        async_reset("rst_clear");
        set_search(10'h155); tick();
        set_search(10'h0F0); tick();
        repeat (3) tick();

        // reset with a search in flight: no strobe may appear afterwards
        set_write(1, 10'h3C3, 10'h000, 1'b1); tick();
        set_search(10'h3C3); tick();
        async_reset("rst_search");
        repeat (4) tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 40) begin
                set_write(int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom),
                          DATA_W'($urandom & $urandom & $urandom), $urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 99) < 60) begin
                e = int'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 1) == 1)
                    set_search(m_data[e] ^ (DATA_W'($urandom) & m_mask[e]));
                else
                    set_search(DATA_W'($urandom));
            end
            if ($urandom_range(0, 99) < 2) clr = 1'b1;
            tick();
        end

        // drain with a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tcam_ternary.md
TCAM_TERNARY -- requirements
Module: tcam_ternary

Interface
REQ-001 SHALL have parameter DATA_W, default 10, key/entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries, 2..64.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), entry index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  write strobe, one entry per cycle.
REQ-007 SHALL have port wr_addr  input  ADDR_W  entry to write.
REQ-008 SHALL have port wr_data  input  DATA_W  stored value.
REQ-009 SHALL have port wr_mask  input  DATA_W  per-bit don't-care; 1 = bit ignored in compare.
REQ-010 SHALL have port wr_valid  input  1  1 = entry valid; 0 = invalidate entry.
REQ-011 SHALL have port clr  input  1  pulse starting a sequential clear of all entries.
REQ-012 SHALL have port srch_valid  input  1  search request.
REQ-013 SHALL have port srch_key  input  DATA_W  search key.
REQ-014 SHALL have port srch_ready  output  1  search accepted when srch_valid and srch_ready are both high.
REQ-015 SHALL have port busy  output  1  clear sweep in progress.
REQ-016 SHALL have port rslt_valid  output  1  one-cycle result strobe.
REQ-017 SHALL have port rslt_hit  output  1  at least one valid entry matched.
REQ-018 SHALL have port rslt_addr  output  ADDR_W  lowest matching index; 0 on miss.
REQ-019 SHALL have port rslt_multi  output  1  two or more entries matched.

Function
REQ-020 SHALL treat entry i as matching when valid[i] and ((key ^ data[i]) & ~mask[i]) == 0.
REQ-021 SHALL use a 2-stage pipeline: S1 registers the DEPTH-bit match vector; S2 registers the priority-encoded result.
REQ-022 SHALL assert rslt_valid exactly 2 cycles after an accepted search, with one result per accept, fully pipelined at 1 search/cycle.
REQ-023 SHALL resolve priority so the lowest index wins.
REQ-024 SHALL evaluate a search accepted in the same cycle as a write to the same entry against the pre-write contents; the write takes effect for the next accepted search.
REQ-025 SHALL use the FSM IDLE -> CLEAR on clr while IDLE; CLEAR invalidates entry cnt and increments cnt each cycle; CLEAR -> IDLE after entry DEPTH-1.
REQ-026 SHALL, while in CLEAR, hold busy=1 and srch_ready=0, and ignore wr_en; otherwise srch_ready=1.
REQ-027 SHALL ignore clr while in CLEAR (no restart).
REQ-028 SHALL let searches already in the pipeline when clr is accepted complete using the contents from their S1 cycle.
REQ-029 SHALL clear only valid bits on clear; data and mask are retained.
REQ-030 SHALL treat a write with wr_addr >= DEPTH as a no-op.

Reset
REQ-031 SHALL, while reset_n is low, asynchronously clear all valid bits, FSM=IDLE, cnt=0, pipeline valid bits=0, rslt_valid=0, rslt_hit=0, rslt_addr=0, rslt_multi=0, busy=0.
REQ-032 SHALL, on reset asserted mid-CLEAR or mid-search, abort the operation with no result strobe.
REQ-033 SHALL not reset data and mask storage.

Configuration
REQ-034 SHALL, when TCAM_SEG7_EN is defined, add outputs seg_lo and seg_hi (7 bits each) showing rslt_addr as two decimal digits.
REQ-035 SHALL encode those digits in abcdefg active-high form (0=1111110, 1=0110000 ... 9=1111011), registered in the S2 cycle, reset to the "0" pattern, and holding their value on a miss.
REQ-036 SHALL, without TCAM_SEG7_EN, omit those ports and the decode logic, leaving all other behaviour unchanged.

Structure
REQ-037 SHALL place the FSM state enum (IDLE, CLEAR) and the 7-segment digit constants in shared package tcam_pkg.
REQ-038 SHALL implement priority encoding in sub-module tcam_prio_enc (parameter DEPTH; outputs hit, idx, multi), purely combinational.

Verification
REQ-039 SHALL cover: write entry 3 = 10'h2A5 with mask 0, search 10'h2A5 -> 2 cycles later rslt_valid=1, hit=1, addr=3, multi=0.
REQ-040 SHALL cover: entry 5 = 10'h200 with mask 10'h0FF, entry 9 = 10'h2A5 with mask 0; search 10'h2A5 -> hit=1, addr=5, multi=1.
REQ-041 SHALL cover: back-to-back searches 10'h2A5, 10'h111, 10'h2A5 on consecutive cycles -> three consecutive result strobes: hit, miss (addr=0), hit.
REQ-042 SHALL cover: write entry 7 = 10'h0F0 in the same cycle as a search for 10'h0F0 -> miss; repeat the search next cycle -> hit at addr=7.
REQ-043 SHALL cover: clr pulse with DEPTH=16 -> busy high for exactly 16 cycles with srch_ready=0 throughout; a write during that window is ignored; a subsequent search misses.
REQ-044 SHALL cover: reset_n low during cycle 4 of CLEAR -> all outputs 0 immediately; after release the FSM is IDLE and all entries miss.
